predicate_reg_block: RTL and testbench

- Per-warp, per-lane 1-bit predicate register file for the SIMT core.
- Holds 16 predicate registers for each of 8 lanes and each of 16 warps.
- Has one synchronous write port and two combinational read ports; per-lane enables give lane masking.
- Sits beside the general register file and is read at operand fetch and written at writeback.

---
 rtl/predicate_reg_pkg.sv | 13 +
 rtl/predicate_lane_bank.sv | 41 ++++
 rtl/predicate_reg_block.sv | 70 +++++++
 tb/tb_predicate_reg_block.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/predicate_reg_pkg.sv
// Shared sizing constants and index types for the per-warp, per-lane predicate register file.
package predicate_reg_pkg;

  localparam int NUM_WARPS   = 16;
  localparam int NUM_LANES   = 8;
  localparam int NUM_PREGS   = 16;
  localparam int WARP_W      = $clog2(NUM_WARPS);
  localparam int PREG_ADDR_W = $clog2(NUM_PREGS);

  typedef logic [WARP_W-1:0]      warp_idx_t;
  typedef logic [PREG_ADDR_W-1:0] preg_addr_t;

endpackage

// File: rtl/predicate_lane_bank.sv
// One lane's slice of the predicate file: NUM_WARPS x NUM_PREGS bits,
// one synchronous write port and two enable-gated combinational read ports.
module predicate_lane_bank
  import predicate_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  warp_idx_t  warp_selector,
  input  logic       write_en,
  input  preg_addr_t waddr,
  input  logic       wdata,
  input  logic       read_en_0,
  input  preg_addr_t raddr_0,
  output logic       rdata_0,
  input  logic       read_en_1,
  input  preg_addr_t raddr_1,
  output logic       rdata_1
);

  logic [NUM_PREGS-1:0] mem [NUM_WARPS];

  // Reset wins over a same-cycle write so the whole bank comes up cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        mem[w] <= '0;
      end
    end else if (write_en) begin
      mem[warp_selector][waddr] <= wdata;
    end
  end

  // Reads see pre-edge contents, giving old-data semantics on read-during-write.
  always_comb begin
    rdata_0 = 1'b0;
    rdata_1 = 1'b0;
    if (read_en_0) rdata_0 = mem[warp_selector][raddr_0];
    if (read_en_1) rdata_1 = mem[warp_selector][raddr_1];
  end

endmodule

// File: rtl/predicate_reg_block.sv
// Predicate register file top: fans the scalar per-lane ports into one
// predicate_lane_bank per SIMD lane.
module predicate_reg_block
  import predicate_reg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  warp_idx_t            warp_selector,
  input  logic [NUM_LANES-1:0] read_en_0,
  input  logic [NUM_LANES-1:0] read_en_1,
  input  preg_addr_t           raddr_0,
  input  preg_addr_t           raddr_1,
  input  logic [NUM_LANES-1:0] write_en,
  input  preg_addr_t           waddr,
  input  logic                 wdata_0,
  input  logic                 wdata_1,
  input  logic                 wdata_2,
  input  logic                 wdata_3,
  input  logic                 wdata_4,
  input  logic                 wdata_5,
  input  logic                 wdata_6,
  input  logic                 wdata_7,
  output logic                 rdata_0_0,
  output logic                 rdata_0_1,
  output logic                 rdata_0_2,
  output logic                 rdata_0_3,
  output logic                 rdata_0_4,
  output logic                 rdata_0_5,
  output logic                 rdata_0_6,
  output logic                 rdata_0_7,
  output logic                 rdata_1_0,
  output logic                 rdata_1_1,
  output logic                 rdata_1_2,
  output logic                 rdata_1_3,
  output logic                 rdata_1_4,
  output logic                 rdata_1_5,
  output logic                 rdata_1_6,
  output logic                 rdata_1_7
);

  logic [NUM_LANES-1:0] wdata_vec;
  logic [NUM_LANES-1:0] rdata_0_vec;
  logic [NUM_LANES-1:0] rdata_1_vec;

  assign wdata_vec = {wdata_7, wdata_6, wdata_5, wdata_4,
                      wdata_3, wdata_2, wdata_1, wdata_0};

  assign {rdata_0_7, rdata_0_6, rdata_0_5, rdata_0_4,
          rdata_0_3, rdata_0_2, rdata_0_1, rdata_0_0} = rdata_0_vec;
  assign {rdata_1_7, rdata_1_6, rdata_1_5, rdata_1_4,
          rdata_1_3, rdata_1_2, rdata_1_1, rdata_1_0} = rdata_1_vec;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    predicate_lane_bank u_bank (
      .clk           (clk),
      .rst           (rst),
      .warp_selector (warp_selector),
      .write_en      (write_en[i]),
      .waddr         (waddr),
      .wdata         (wdata_vec[i]),
      .read_en_0     (read_en_0[i]),
      .raddr_0       (raddr_0),
      .rdata_0       (rdata_0_vec[i]),
      .read_en_1     (read_en_1[i]),
      .raddr_1       (raddr_1),
      .rdata_1       (rdata_1_vec[i])
    );
  end

endmodule

// File: tb/tb_predicate_reg_block.sv
// Directed self-checking bench for predicate_reg_block: reset, sweep, isolation,
// lane masking, dual-port, read-during-write and reset-over-write scenarios.
module tb_predicate_reg_block;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] warp_selector;
  logic [7:0] read_en_0, read_en_1, write_en;
  logic [3:0] raddr_0, raddr_1, waddr;
  logic [7:0] wd;
  logic [7:0] rd0, rd1;
  logic rdata_0_0, rdata_0_1, rdata_0_2, rdata_0_3, rdata_0_4, rdata_0_5, rdata_0_6, rdata_0_7;
  logic rdata_1_0, rdata_1_1, rdata_1_2, rdata_1_3, rdata_1_4, rdata_1_5, rdata_1_6, rdata_1_7;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rd0 = {rdata_0_7, rdata_0_6, rdata_0_5, rdata_0_4, rdata_0_3, rdata_0_2, rdata_0_1, rdata_0_0};
  assign rd1 = {rdata_1_7, rdata_1_6, rdata_1_5, rdata_1_4, rdata_1_3, rdata_1_2, rdata_1_1, rdata_1_0};

  predicate_reg_block dut (
    .clk(clk), .rst(rst), .warp_selector(warp_selector),
    .read_en_0(read_en_0), .read_en_1(read_en_1),
    .raddr_0(raddr_0), .raddr_1(raddr_1),
    .write_en(write_en), .waddr(waddr),
    .wdata_0(wd[0]), .wdata_1(wd[1]), .wdata_2(wd[2]), .wdata_3(wd[3]),
    .wdata_4(wd[4]), .wdata_5(wd[5]), .wdata_6(wd[6]), .wdata_7(wd[7]),
    .rdata_0_0(rdata_0_0), .rdata_0_1(rdata_0_1), .rdata_0_2(rdata_0_2), .rdata_0_3(rdata_0_3),
    .rdata_0_4(rdata_0_4), .rdata_0_5(rdata_0_5), .rdata_0_6(rdata_0_6), .rdata_0_7(rdata_0_7),
    .rdata_1_0(rdata_1_0), .rdata_1_1(rdata_1_1), .rdata_1_2(rdata_1_2), .rdata_1_3(rdata_1_3),
    .rdata_1_4(rdata_1_4), .rdata_1_5(rdata_1_5), .rdata_1_6(rdata_1_6), .rdata_1_7(rdata_1_7)
  );

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] w, input logic [3:0] a, input logic [7:0] en, input logic [7:0] d);
    warp_selector = w; waddr = a; write_en = en; wd = d;
    @(posedge clk); #1;
    write_en = 8'h00;
  endtask

  task automatic set_read(input logic [3:0] w, input logic [7:0] e0, input logic [3:0] a0,
                          input logic [7:0] e1, input logic [3:0] a1);
    warp_selector = w; read_en_0 = e0; raddr_0 = a0; read_en_1 = e1; raddr_1 = a1;
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] w;
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 4'd0 : 4'd15;
      for (int r = 0; r < 16; r++) begin
        set_read(w, 8'hFF, 4'(r), 8'hFF, 4'(r));
        checks++;
        if (rd0 !== 8'h00) begin
          failures++;
          $display("[TB] FAIL reset_p0 w=%0d r=%0d got=%h exp=00", w, r, rd0);
        end
        checks++;
        if (rd1 !== 8'h00) begin
          failures++;
          $display("[TB] FAIL reset_p1 w=%0d r=%0d got=%h exp=00", w, r, rd1);
        end
      end
    end
  endtask

  task automatic test_full_sweep();
    for (int w = 0; w < 16; w++) begin
      for (int r = 0; r < 16; r++) begin
        do_write(4'(w), 4'(r), 8'hFF, 8'hFF);
        set_read(4'(w), 8'hFF, 4'(r), 8'h00, 4'(r));
        checks++;
        if (rd0 !== 8'hFF || rd1 !== 8'h00) begin
          failures++;
          $display("[TB] FAIL sweep_p0 w=%0d r=%0d got=%h/%h exp=ff/00", w, r, rd0, rd1);
        end
        set_read(4'(w), 8'h00, 4'(r), 8'hFF, 4'(r));
        checks++;
        if (rd0 !== 8'h00 || rd1 !== 8'hFF) begin
          failures++;
          $display("[TB] FAIL sweep_p1 w=%0d r=%0d got=%h/%h exp=00/ff", w, r, rd0, rd1);
        end
        set_read(4'(w), 8'hFF, 4'(r), 8'hFF, 4'(r));
        checks++;
        if (rd0 !== 8'hFF || rd1 !== 8'hFF) begin
          failures++;
          $display("[TB] FAIL sweep_both w=%0d r=%0d got=%h/%h exp=ff/ff", w, r, rd0, rd1);
        end
      end
    end
  endtask

  task automatic test_isolation();
    pulse_reset();
    do_write(4'd3, 4'd5, 8'hFF, 8'hFF);
    set_read(4'd4, 8'hFF, 4'd5, 8'hFF, 4'd5);
    checks++;
    if (rd0 !== 8'h00) begin
      failures++;
      $display("[TB] FAIL iso_other_warp got=%h exp=00", rd0);
    end
    set_read(4'd3, 8'hFF, 4'd6, 8'hFF, 4'd5);
    checks++;
    if (rd0 !== 8'h00) begin
      failures++;
      $display("[TB] FAIL iso_other_reg got=%h exp=00", rd0);
    end
    checks++;
    if (rd1 !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL iso_target got=%h exp=ff", rd1);
    end
  endtask

  task automatic test_lane_masking();
    pulse_reset();
    do_write(4'd2, 4'd1, 8'h0F, 8'hFF);
    set_read(4'd2, 8'hFF, 4'd1, 8'hFF, 4'd1);
    checks++;
    if (rd0 !== 8'h0F || rd1 !== 8'h0F) begin
      failures++;
      $display("[TB] FAIL mask_write got=%h/%h exp=0f/0f", rd0, rd1);
    end
    do_write(4'd2, 4'd3, 8'hFF, 8'hFF);
    set_read(4'd2, 8'hAA, 4'd3, 8'hFF, 4'd3);
    checks++;
    if (rd0 !== 8'hAA) begin
      failures++;
      $display("[TB] FAIL mask_read got=%h exp=aa", rd0);
    end
    checks++;
    if (rd1 !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL mask_read_p1 got=%h exp=ff", rd1);
    end
    // Distinct per-lane data catches any lane swap in the fan-in/fan-out.
    do_write(4'd2, 4'd4, 8'hFF, 8'h5A);
    do_write(4'd2, 4'd4, 8'h81, 8'hC3);
    set_read(4'd2, 8'hFF, 4'd4, 8'h3C, 4'd4);
    checks++;
    if (rd0 !== 8'hDB || rd1 !== 8'h18) begin
      failures++;
      $display("[TB] FAIL lane_pattern got=%h/%h exp=db/18", rd0, rd1);
    end
  endtask

  task automatic test_dual_port();
    do_write(4'd6, 4'd2, 8'hFF, 8'hFF);
    do_write(4'd6, 4'd9, 8'hFF, 8'h00);
    set_read(4'd6, 8'hFF, 4'd2, 8'hFF, 4'd9);
    checks++;
    if (rd0 !== 8'hFF || rd1 !== 8'h00) begin
      failures++;
      $display("[TB] FAIL dual_diff got=%h/%h exp=ff/00", rd0, rd1);
    end
    do_write(4'd6, 4'd2, 8'hFF, 8'h00);
    set_read(4'd6, 8'hFF, 4'd2, 8'hFF, 4'd9);
    checks++;
    if (rd0 !== 8'h00) begin
      failures++;
      $display("[TB] FAIL dual_overwrite got=%h exp=00", rd0);
    end
  endtask

  task automatic test_read_during_write();
    do_write(4'd9, 4'd7, 8'hFF, 8'h00);
    set_read(4'd9, 8'hFF, 4'd7, 8'hFF, 4'd7);
    waddr = 4'd7; write_en = 8'hFF; wd = 8'hFF;
    #1;
    checks++;
    if (rd0 !== 8'h00 || rd1 !== 8'h00) begin
      failures++;
      $display("[TB] FAIL rdw_before got=%h/%h exp=00/00", rd0, rd1);
    end
    @(posedge clk); #1;
    write_en = 8'h00;
    checks++;
    if (rd0 !== 8'hFF || rd1 !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL rdw_after got=%h/%h exp=ff/ff", rd0, rd1);
    end
  endtask

  task automatic test_back_to_back();
    do_write(4'd11, 4'd0, 8'hFF, 8'h96);
    do_write(4'd11, 4'd1, 8'hFF, 8'h69);
    do_write(4'd12, 4'd0, 8'hFF, 8'hF0);
    set_read(4'd11, 8'hFF, 4'd0, 8'hFF, 4'd1);
    checks++;
    if (rd0 !== 8'h96 || rd1 !== 8'h69) begin
      failures++;
      $display("[TB] FAIL b2b_w11 got=%h/%h exp=96/69", rd0, rd1);
    end
    set_read(4'd12, 8'hFF, 4'd0, 8'hFF, 4'd1);
    checks++;
    if (rd0 !== 8'hF0 || rd1 !== 8'h00) begin
      failures++;
      $display("[TB] FAIL b2b_warp_switch got=%h/%h exp=f0/00", rd0, rd1);
    end
  endtask

  task automatic test_reset_mid_run();
    do_write(4'd0, 4'd0, 8'hFF, 8'hFF);
    do_write(4'd15, 4'd15, 8'hFF, 8'hFF);
    warp_selector = 4'd0; waddr = 4'd0; write_en = 8'hFF; wd = 8'hFF; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; write_en = 8'h00;
    for (int w = 0; w < 16; w++) begin
      for (int r = 0; r < 16; r++) begin
        set_read(4'(w), 8'hFF, 4'(r), 8'hFF, 4'(r));
        checks++;
        if (rd0 !== 8'h00 || rd1 !== 8'h00) begin
          failures++;
          $display("[TB] FAIL rst_mid w=%0d r=%0d got=%h/%h exp=00/00", w, r, rd0, rd1);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; warp_selector = 4'd0; waddr = 4'd0; raddr_0 = 4'd0; raddr_1 = 4'd0;
    read_en_0 = 8'h00; read_en_1 = 8'h00; write_en = 8'h00; wd = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_full_sweep();
    test_isolation();
    test_lane_masking();
    test_dual_port();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
